// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: combinational ROM port, fetch/redirect controls and the
// decode-side handshake. master = fetch_ctrl, slave = environment.
interface fetch_ctrl_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output rom_addr, id_valid, id_inst, id_pc, id_pc4,
        input  rom_inst, fetch_en, redirect, redirect_pc, id_ready
    );
    modport slave (
        input  rom_addr, id_valid, id_inst, id_pc, id_pc4,
        output rom_inst, fetch_en, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks fetch_pc through a combinational ROM and
// queues {pc, inst} pairs in a small circular buffer feeding decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(BUF_DEPTH - 1);
    localparam logic [31:0]   START_PC = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t        state, state_nx;
    entry_t        fifo [BUF_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nx;
    logic [31:0]   fetch_pc;
    logic          push, pop;

    always_comb begin
        pop      = 1'b0;
        push     = 1'b0;
        count_nx = count;
        state_nx = state;
        pop  = (state != EMPTY) & bus.id_ready & ~bus.redirect;
        // A pop frees a slot in the same cycle, so a full buffer still streams.
        push = bus.fetch_en & ~bus.redirect & ((state != FULL) | pop);
        if (bus.redirect)
            count_nx = '0;
        else if (push & ~pop)
            count_nx = count + 1'b1;
        else if (pop & ~push)
            count_nx = count - 1'b1;
        if (count_nx == '0)
            state_nx = EMPTY;
        else if (count_nx == DEPTH_C)
            state_nx = FULL;
        else
            state_nx = PARTIAL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            fetch_pc <= START_PC;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (bus.redirect) begin
                wptr     <= '0;
                rptr     <= '0;
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (push) begin
                    wptr     <= (wptr == LAST) ? '0 : wptr + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop)
                    rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wptr] <= '{pc: fetch_pc, inst: bus.rom_inst};
    end

    assign bus.rom_addr = fetch_pc;
    assign bus.id_valid = (state != EMPTY);
    assign bus.id_inst  = (state != EMPTY) ? fifo[rptr].inst : 32'h0;
    assign bus.id_pc    = (state != EMPTY) ? fifo[rptr].pc   : 32'h0;
    assign bus.id_pc4   = bus.id_pc + 32'd4;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (BUF_DEPTH=2): a vector table for streaming,
// backpressure, drain and redirect, plus hand sequences for reset behaviour.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h0010_0443;
            32'h0000_0004: rom_word = 32'h0020_1025;
            default:       rom_word = a ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_addr);

    typedef struct {
        logic        fe;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] erom;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fe, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic ev, input logic [31:0] epc,
                       input logic [31:0] erom);
        vec_t v;
        v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.erom = erom;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Head expectations: inst follows the ROM model, pc4 follows pc.
    task automatic chk_head(input string nm, input logic ev, input logic [31:0] epc,
                            input logic [31:0] erom);
        logic [31:0] einst;
        einst = ev ? rom_word(epc) : 32'h0;
        chk({nm, ".valid"}, {31'h0, bus.id_valid}, {31'h0, ev});
        chk({nm, ".pc"},    bus.id_pc,    epc);
        chk({nm, ".inst"},  bus.id_inst,  einst);
        chk({nm, ".pc4"},   bus.id_pc4,   epc + 32'd4);
        chk({nm, ".rom"},   bus.rom_addr, erom);
    endtask

    initial begin
        bus.fetch_en    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready    = 1'b0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1 chk_head("reset", 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //    fe    rd    rpc           rdy   ev    epc           rom
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h4);       // push 0
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8);       // push 4, full
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8);       // full holds pc
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8);
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'hC);       // stream at full
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h10);
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h14);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        32'h14);      // frozen
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h14);      // drain
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h14);      // empty
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h14);      // ready while empty
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       32'h18);
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       32'h1C);      // full
        add(1'b1, 1'b1, 32'h17,       1'b1, 1'b0, 32'h0,        32'h14);      // flush beats pop
        add(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h14,       32'h18);      // target first
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h18,       32'h1C);
        add(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'hFFFF_FFFC);
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);      // pc wraps
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4);

        for (int i = 0; i < vq.size(); i++) begin
            bus.fetch_en    = vq[i].fe;
            bus.redirect    = vq[i].rd;
            bus.redirect_pc = vq[i].rpc;
            bus.id_ready    = vq[i].rdy;
            @(posedge clk);
            #1 chk_head($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].erom);
            @(negedge clk);
        end
        bus.redirect = 1'b0;

        // Fill to two entries, then pulse reset between edges.
        bus.fetch_en = 1'b1;
        bus.id_ready = 1'b0;
        @(posedge clk);
        #1 chk_head("prefill", 1'b1, 32'h0, 32'h8);
        @(negedge clk);
        bus.fetch_en = 1'b0;
        rst = 1'b1;
        #1 chk_head("async_rst", 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk_head("post_rst", 1'b0, 32'h0, 32'h0);

        // First push at the first edge with fetch_en high, then stream.
        @(negedge clk) bus.fetch_en = 1'b1;
        @(posedge clk);
        #1 chk_head("first_push", 1'b1, 32'h0, 32'h4);
        chk("word0", bus.id_inst, 32'h0010_0443);
        @(negedge clk) bus.id_ready = 1'b1;
        @(posedge clk);
        #1 chk_head("stream1", 1'b1, 32'h4, 32'h8);
        chk("word1", bus.id_inst, 32'h0020_1025);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
